cf_fft_stage_seq: RTL and testbench

//  Control sequencer for an in-place radix-2 FFT datapath of N = 2**LOG2N points.

---
 rtl/cf_fft_stage_seq_if.sv | 25 ++
 rtl/cf_fft_stage_seq.sv | 114 +++++++++++
 tb/tb_cf_fft_stage_seq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cf_fft_stage_seq_if.sv
// cf_fft_stage_seq_if: control and butterfly-address bundle between the FFT sequencer and its host
interface cf_fft_stage_seq_if #(parameter int LOG2N = 10);
    localparam int STAGE_W = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);
    logic clear;
    logic enable;
    logic start;
    logic inverse;
    logic busy;
    logic bfly_valid;
    logic [LOG2N-1:0] addr_a;
    logic [LOG2N-1:0] addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic tw_conj;
    logic [STAGE_W-1:0] stage;
    logic bank_sel;
    logic done;
    modport master (
        output clear, enable, start, inverse,
        input busy, bfly_valid, addr_a, addr_b, tw_idx, tw_conj, stage, bank_sel, done
    );
    modport slave (
        input clear, enable, start, inverse,
        output busy, bfly_valid, addr_a, addr_b, tw_idx, tw_conj, stage, bank_sel, done
    );
endinterface

// File: rtl/cf_fft_stage_seq.sv
// cf_fft_stage_seq: walks all stages of an in-place radix-2 FFT, issuing butterfly addresses and twiddles
module cf_fft_stage_seq #(
    parameter int LOG2N = 10,
    parameter int STAGE_GAP = 4
) (
    input logic clock_c,
    input logic reset_n,
    cf_fft_stage_seq_if.slave bus
);
    localparam int STAGE_W = ($clog2(LOG2N) < 1) ? 1 : $clog2(LOG2N);
    localparam int KW = LOG2N - 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [STAGE_W-1:0] LAST_S = STAGE_W'(LOG2N - 1);
    localparam logic [GW-1:0] LAST_G = GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);
    localparam logic [LOG2N-1:0] ONE = LOG2N'(1);
    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
    state_t state, nxt_state;
    logic [KW-1:0] k, nxt_k;
    logic [STAGE_W-1:0] s, nxt_s;
    logic [GW-1:0] g, nxt_g;
    logic nxt_bank, nxt_conj, stage_end;
    logic [LOG2N-1:0] kx, mask, nxt_a, nxt_b;
    logic [KW-1:0] nxt_tw;

    assign bus.stage = s;

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            k <= '0;
            s <= '0;
            g <= '0;
            bus.bank_sel <= 1'b0;
            bus.tw_conj <= 1'b0;
            bus.busy <= 1'b0;
            bus.bfly_valid <= 1'b0;
            bus.done <= 1'b0;
            bus.addr_a <= '0;
            bus.addr_b <= '0;
            bus.tw_idx <= '0;
        end else begin
            state <= nxt_state;
            k <= nxt_k;
            s <= nxt_s;
            g <= nxt_g;
            bus.bank_sel <= nxt_bank;
            bus.tw_conj <= nxt_conj;
            bus.busy <= (nxt_state == RUN) || (nxt_state == GAP);
            bus.bfly_valid <= bus.enable && !bus.clear && (nxt_state == RUN);
            bus.done <= bus.enable && !bus.clear && (nxt_state == DONE);
            bus.addr_a <= nxt_a;
            bus.addr_b <= nxt_b;
            bus.tw_idx <= nxt_tw;
        end
    end

    // clear is folded in last so it overrides everything the enable path decided
    always_comb begin
        nxt_state = state;
        nxt_k = k;
        nxt_s = s;
        nxt_g = g;
        nxt_bank = bus.bank_sel;
        nxt_conj = bus.tw_conj;
        stage_end = 1'b0;
        if (bus.enable) begin
            unique case (state)
                IDLE: if (bus.start) begin
                    nxt_state = RUN;
                    nxt_k = '0;
                    nxt_s = '0;
                    nxt_g = '0;
                    nxt_bank = 1'b0;
                    nxt_conj = bus.inverse;
                end
                RUN: begin
                    nxt_k = k + KW'(1);
                    if (&k) begin
                        nxt_state = GAP;
                        nxt_g = '0;
                        stage_end = (STAGE_GAP == 0);
                    end
                end
                GAP: begin
                    nxt_g = g + GW'(1);
                    stage_end = (g == LAST_G);
                end
                DONE: nxt_state = IDLE;
            endcase
        end
        if (stage_end) begin
            nxt_state = (s == LAST_S) ? DONE : RUN;
            nxt_s = (s == LAST_S) ? s : s + STAGE_W'(1);
            nxt_bank = bus.bank_sel ^ (s != LAST_S);
        end
        if (bus.clear) begin
            nxt_state = IDLE;
            nxt_k = '0;
            nxt_s = '0;
            nxt_g = '0;
            nxt_bank = 1'b0;
            nxt_conj = 1'b0;
        end
    end

    // insert a zero at bit s of k to get the top operand; the bottom one sets that bit
    always_comb begin
        kx = LOG2N'(nxt_k);
        mask = (ONE << nxt_s) - ONE;
        nxt_a = (nxt_state == RUN) ? (((kx & ~mask) << 1) | (kx & mask)) : '0;
        nxt_b = (nxt_state == RUN) ? (nxt_a | (ONE << nxt_s)) : '0;
        nxt_tw = (nxt_state == RUN) ? KW'((kx & mask) << (KW - 32'(nxt_s))) : '0;
    end
endmodule

// File: tb/tb_cf_fft_stage_seq.sv
// tb_cf_fft_stage_seq: directed checks of the FFT stage sequencer in three size/gap configurations
module tb_cf_fft_stage_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_checks = 0;
    int n_errors = 0;
    int a_tab [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int b_tab [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int t_tab [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    int seen [10][1024];
    int exp_v, cnt, bad, ndone, done_c, cyc, nvalid, diff_err, once_err;

    cf_fft_stage_seq_if #(.LOG2N(3)) b0 ();
    cf_fft_stage_seq_if #(.LOG2N(3)) b1 ();
    cf_fft_stage_seq_if #(.LOG2N(10)) b2 ();

    cf_fft_stage_seq #(.LOG2N(3), .STAGE_GAP(0)) u0 (.clock_c(clk), .reset_n(reset_n), .bus(b0.slave));
    cf_fft_stage_seq #(.LOG2N(3), .STAGE_GAP(2)) u1 (.clock_c(clk), .reset_n(reset_n), .bus(b1.slave));
    cf_fft_stage_seq #(.LOG2N(10), .STAGE_GAP(4)) u2 (.clock_c(clk), .reset_n(reset_n), .bus(b2.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero0(input string tag);
        check({tag, "_busy"}, int'(b0.busy), 0);
        check({tag, "_valid"}, int'(b0.bfly_valid), 0);
        check({tag, "_a"}, int'(b0.addr_a), 0);
        check({tag, "_b"}, int'(b0.addr_b), 0);
        check({tag, "_tw"}, int'(b0.tw_idx), 0);
        check({tag, "_conj"}, int'(b0.tw_conj), 0);
        check({tag, "_stage"}, int'(b0.stage), 0);
        check({tag, "_bank"}, int'(b0.bank_sel), 0);
        check({tag, "_done"}, int'(b0.done), 0);
    endtask

    initial begin
        {b0.clear, b0.enable, b0.start, b0.inverse} = 4'b0;
        {b1.clear, b1.enable, b1.start, b1.inverse} = 4'b0;
        {b2.clear, b2.enable, b2.start, b2.inverse} = 4'b0;
        tick(2);
        check_zero0("reset");
        reset_n = 1'b1;
        tick();
        check_zero0("idle");

        // full pass, no gap
        b0.enable = 1'b1;
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("t1_valid", int'(b0.bfly_valid), 1);
            check("t1_busy", int'(b0.busy), 1);
            check("t1_a", int'(b0.addr_a), a_tab[i]);
            check("t1_b", int'(b0.addr_b), b_tab[i]);
            check("t1_tw", int'(b0.tw_idx), t_tab[i]);
            check("t1_stage", int'(b0.stage), i / 4);
            check("t1_bank", int'(b0.bank_sel), (i / 4) % 2);
            tick();
        end
        check("t1_done", int'(b0.done), 1);
        check("t1_done_busy", int'(b0.busy), 0);
        check("t1_done_valid", int'(b0.bfly_valid), 0);
        tick();
        check("t1_done_pulse", int'(b0.done), 0);

        // gap of two cycles between stages
        b1.enable = 1'b1;
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            exp_v = int'((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16));
            check("t2_valid", int'(b1.bfly_valid), exp_v);
            check("t2_busy", int'(b1.busy), int'(c < 19));
            check("t2_done", int'(b1.done), int'(c == 19));
            if (exp_v == 1) check("t2_bank", int'(b1.bank_sel), ((c - 1) / 6) % 2);
            if (c < 19) tick();
        end
        tick();

        // freeze five cycles in the middle of stage 1
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        tick(5);
        check("t3_pre_a", int'(b0.addr_a), 1);
        b0.enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_frz_valid", int'(b0.bfly_valid), 0);
            check("t3_frz_a", int'(b0.addr_a), 1);
            check("t3_frz_b", int'(b0.addr_b), 3);
        end
        b0.enable = 1'b1;
        for (int i = 6; i < 12; i++) begin
            tick();
            check("t3_res_valid", int'(b0.bfly_valid), 1);
            check("t3_res_a", int'(b0.addr_a), a_tab[i]);
            check("t3_res_tw", int'(b0.tw_idx), t_tab[i]);
        end
        tick();
        check("t3_done", int'(b0.done), 1);
        tick();

        // clear mid-pass aborts, start alongside clear is ignored
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        tick(5);
        b0.clear = 1'b1;
        b0.start = 1'b1;
        tick();
        b0.clear = 1'b0;
        b0.start = 1'b0;
        check_zero0("t4_clear");
        bad = 0;
        repeat (15) begin
            tick();
            if (b0.done || b0.busy) bad++;
        end
        check("t4_no_done", bad, 0);
        b0.start = 1'b1;
        b0.inverse = 1'b1;
        tick();
        b0.start = 1'b0;
        b0.inverse = 1'b0;
        bad = 0;
        for (int c = 1; c <= 13; c++) begin
            if (b0.tw_conj !== 1'b1) bad++;
            if (c == 13) check("t4_inv_done", int'(b0.done), 1);
            else tick();
        end
        check("t4_conj", bad, 0);
        tick();

        // start held high: one pass per acceptance, then async reset mid-run
        b0.start = 1'b1;
        tick();
        ndone = 0;
        done_c = 0;
        for (int c = 1; c <= 14; c++) begin
            if (b0.done) begin
                ndone++;
                done_c = c;
            end
            if (c == 14) begin
                check("t5_idle_busy", int'(b0.busy), 0);
                check("t5_idle_valid", int'(b0.bfly_valid), 0);
            end
            tick();
        end
        check("t5_ndone", ndone, 1);
        check("t5_done_cycle", done_c, 13);
        check("t5_restart_valid", int'(b0.bfly_valid), 1);
        check("t5_restart_a", int'(b0.addr_a), 0);
        tick(2);
        b0.start = 1'b0;
        check("t5_mid_busy", int'(b0.busy), 1);
        #2 reset_n = 1'b0;
        #1 check_zero0("t5_async");
        tick();
        reset_n = 1'b1;

        // full-size transform
        b2.enable = 1'b1;
        b2.start = 1'b1;
        tick();
        b2.start = 1'b0;
        cyc = 1;
        nvalid = 0;
        diff_err = 0;
        while (!b2.done && cyc < 6000) begin
            if (b2.bfly_valid) begin
                nvalid++;
                if (int'(b2.addr_b) - int'(b2.addr_a) != (1 << int'(b2.stage))) diff_err++;
                if (int'(b2.stage) < 10) begin
                    seen[b2.stage][b2.addr_a]++;
                    seen[b2.stage][b2.addr_b]++;
                end else diff_err++;
            end
            tick();
            cyc++;
        end
        check("t6_done", int'(b2.done), 1);
        check("t6_done_cycle", cyc, 5161);
        check("t6_nvalid", nvalid, 5120);
        check("t6_span", diff_err, 0);
        once_err = 0;
        for (int st = 0; st < 10; st++)
            for (int ad = 0; ad < 1024; ad++)
                if (seen[st][ad] != 1) once_err++;
        check("t6_once", once_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
